// File: rtl/lsu_nb_if.sv
// Issue, memory and retire signals of the non-blocking LSU, bundled for port use.
// master drives the i_* side (issue stage and memory); slave is the LSU itself.
interface lsu_nb_if #(
  parameter int unsigned XLEN = 32
);
  logic              i_valid;
  logic              o_ready;
  logic              i_is_load;
  logic              i_is_store;
  logic [1:0]        i_size;
  logic              i_sign_ext;
  logic [4:0]        i_rd;
  logic [XLEN-1:0]   i_base;
  logic [XLEN-1:0]   i_imm;
  logic [XLEN-1:0]   i_wdata;
  logic              o_dmem_req_valid;
  logic              i_dmem_req_ready;
  logic [XLEN-1:0]   o_dmem_addr;
  logic              o_dmem_we;
  logic [XLEN-1:0]   o_dmem_wdata;
  logic [XLEN/8-1:0] o_dmem_wstrb;
  logic              i_dmem_rsp_valid;
  logic [XLEN-1:0]   i_dmem_rdata;
  logic              o_valid;
  logic [4:0]        o_rd;
  logic              o_is_load;
  logic [XLEN-1:0]   o_load_data;
  logic              o_misaligned;
  logic [XLEN-1:0]   o_fault_addr;
  logic              o_busy;

  modport master (
    output i_valid, i_is_load, i_is_store, i_size, i_sign_ext, i_rd, i_base, i_imm, i_wdata,
    output i_dmem_req_ready, i_dmem_rsp_valid, i_dmem_rdata,
    input  o_ready, o_dmem_req_valid, o_dmem_addr, o_dmem_we, o_dmem_wdata, o_dmem_wstrb,
    input  o_valid, o_rd, o_is_load, o_load_data, o_misaligned, o_fault_addr, o_busy
  );

  modport slave (
    input  i_valid, i_is_load, i_is_store, i_size, i_sign_ext, i_rd, i_base, i_imm, i_wdata,
    input  i_dmem_req_ready, i_dmem_rsp_valid, i_dmem_rdata,
    output o_ready, o_dmem_req_valid, o_dmem_addr, o_dmem_we, o_dmem_wdata, o_dmem_wstrb,
    output o_valid, o_rd, o_is_load, o_load_data, o_misaligned, o_fault_addr, o_busy
  );
endinterface

// File: rtl/lsu_nb.sv
// Non-blocking load/store unit: in-order tracker of up to DEPTH ops, a one-entry request
// stage toward data memory, lane alignment, misalignment faults and load extension.
module lsu_nb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic     clk,
  input logic     rst_n,
  lsu_nb_if.slave bus
);
  localparam int unsigned SW   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(SW);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = {1'b1, {PW{1'b0}}};

  typedef struct packed {
    logic [4:0]      rd;
    logic            load;
    logic [1:0]      size;
    logic            sext;
    logic            fault;
    logic [XLEN-1:0] addr;
  } entry_t;

  entry_t          trk_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            req_q, req_we_q;
  logic [XLEN-1:0] req_addr_q, req_wdata_q;
  logic [SW-1:0]   req_wstrb_q;
  logic            ret_valid_q, ret_load_q, ret_mis_q;
  logic [4:0]      ret_rd_q;
  logic [XLEN-1:0] ret_data_q, ret_faddr_q;

  logic            ready, accept, push, pop, hs, fault, ld_msb;
  logic [XLEN-1:0] addr, st_data, ld_shift, ld_mask, ld_data;
  logic [SW-1:0]   st_strb;
  logic [OFFW-1:0] off;
  entry_t          new_entry, head;

  assign ready  = (count_q < FULL) && (!req_q || bus.i_dmem_req_ready);
  assign accept = bus.i_valid && ready;
  assign push   = accept && (bus.i_is_load || bus.i_is_store);
  assign hs     = req_q && bus.i_dmem_req_ready;
  assign head   = trk_q[rd_ptr_q];
  // A faulting head needs no response; any other head waits for one.
  assign pop    = (count_q != '0) && (head.fault || bus.i_dmem_rsp_valid);

  always_comb begin
    addr = bus.i_base + bus.i_imm;
    off  = addr[OFFW-1:0];
    case (bus.i_size)
      2'b00:   begin fault = 1'b0;        st_data = XLEN'(bus.i_wdata[7:0]);  st_strb = SW'(8'h01); end
      2'b01:   begin fault = addr[0];     st_data = XLEN'(bus.i_wdata[15:0]); st_strb = SW'(8'h03); end
      2'b10:   begin fault = |addr[1:0];  st_data = XLEN'(bus.i_wdata[31:0]); st_strb = SW'(8'h0F); end
      default: begin
        fault   = (XLEN == 32) || (|addr[2:0]);
        st_data = bus.i_wdata;
        st_strb = SW'(8'hFF);
      end
    endcase
    new_entry = '{rd: bus.i_rd, load: bus.i_is_load, size: bus.i_size, sext: bus.i_sign_ext,
                  fault: fault, addr: addr};
  end

  always_comb begin
    ld_shift = bus.i_dmem_rdata >> {head.addr[OFFW-1:0], 3'b000};
    case (head.size)
      2'b00:   ld_msb = ld_shift[7];
      2'b01:   ld_msb = ld_shift[15];
      2'b10:   ld_msb = ld_shift[31];
      default: ld_msb = ld_shift[XLEN-1];
    endcase
    // Shifting by the full width yields zero, so the full-size mask is all ones.
    ld_mask = ~({XLEN{1'b1}} << (8 << head.size));
    ld_data = (ld_shift & ld_mask) | ((head.sext && ld_msb) ? ~ld_mask : '0);
  end

  always_ff @(posedge clk) begin
    if (push) trk_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_q       <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      ret_valid_q <= 1'b0;
      ret_load_q  <= 1'b0;
      ret_mis_q   <= 1'b0;
      ret_rd_q    <= '0;
      ret_data_q  <= '0;
      ret_faddr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + (PW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (PW + 1)'(1);

      if (push && !fault) begin
        req_q       <= 1'b1;
        req_we_q    <= !bus.i_is_load;
        req_addr_q  <= addr;
        req_wdata_q <= st_data << {off, 3'b000};
        req_wstrb_q <= bus.i_is_load ? '0 : st_strb << off;
      end else if (hs) begin
        req_q <= 1'b0;
      end

      ret_valid_q <= pop;
      ret_rd_q    <= pop ? head.rd : '0;
      ret_load_q  <= pop && head.load;
      ret_mis_q   <= pop && head.fault;
      ret_faddr_q <= (pop && head.fault) ? head.addr : '0;
      ret_data_q  <= (pop && head.load && !head.fault) ? ld_data : '0;
    end
  end

  assign bus.o_ready          = ready;
  assign bus.o_dmem_req_valid = req_q;
  assign bus.o_dmem_addr      = req_addr_q;
  assign bus.o_dmem_we        = req_we_q;
  assign bus.o_dmem_wdata     = req_wdata_q;
  assign bus.o_dmem_wstrb     = req_wstrb_q;
  assign bus.o_valid          = ret_valid_q;
  assign bus.o_rd             = ret_rd_q;
  assign bus.o_is_load        = ret_load_q;
  assign bus.o_load_data      = ret_data_q;
  assign bus.o_misaligned     = ret_mis_q;
  assign bus.o_fault_addr     = ret_faddr_q;
  assign bus.o_busy           = (count_q != '0) || req_q;

  a_rsp_empty: assert property (@(posedge clk) disable iff (!rst_n)
    bus.i_dmem_rsp_valid |-> (count_q != '0))
    else $error("lsu_nb: response with empty tracker");
  a_rsp_fault: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.i_dmem_rsp_valid && count_q != '0) |-> !head.fault)
    else $error("lsu_nb: response while head op is faulting");
endmodule

// File: tb/tb_lsu_nb.sv
// Randomised and directed bench for lsu_nb against a queue-based reference model.
module tb_lsu_nb;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic        load;
    logic [1:0]  size;
    logic        sext;
    logic        fault;
    logic [31:0] addr;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_nb_if #(.XLEN(XLEN)) bus ();
  lsu_nb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  op_t         trk[$];
  bit          req_v;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  int          issued;
  bit          ret_v;
  logic        ret_load, ret_mis;
  logic [4:0]  ret_rd;
  logic [31:0] ret_data, ret_faddr;
  int          checks, failures;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [3:0] size_strb(input logic [1:0] size);
    case (size)
      2'd0:    return 4'h1;
      2'd1:    return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_result(input logic [31:0] raw, input op_t o);
    logic [31:0] m, v;
    m = size_mask(o.size);
    v = (raw >> (8 * o.addr[1:0])) & m;
    if (o.sext && ((v & ((m >> 1) + 32'd1)) != 0)) v = v | ~m;
    return v;
  endfunction

  function automatic bit rsp_ok();
    return trk.size() != 0 && !trk[0].fault && issued > 0;
  endfunction

  task automatic model_reset();
    trk.delete();
    req_v  = 1'b0;
    issued = 0;
    ret_v  = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.i_valid = 1'b0; bus.i_is_load = 1'b0; bus.i_is_store = 1'b0; bus.i_size = 2'd0;
    bus.i_sign_ext = 1'b0; bus.i_rd = 5'd0; bus.i_base = '0; bus.i_imm = '0; bus.i_wdata = '0;
    bus.i_dmem_req_ready = 1'b0; bus.i_dmem_rsp_valid = 1'b0; bus.i_dmem_rdata = '0;
  endtask

  task automatic set_op(input bit v, input bit ld, input bit st, input logic [1:0] sz,
                        input bit sx, input logic [4:0] rd, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] wd);
    bus.i_valid = v; bus.i_is_load = ld; bus.i_is_store = st; bus.i_size = sz;
    bus.i_sign_ext = sx; bus.i_rd = rd; bus.i_base = base; bus.i_imm = imm; bus.i_wdata = wd;
  endtask

  // Called at a falling edge with inputs driven: checks outputs, advances the model one cycle.
  task automatic tick();
    bit  rdy;
    op_t h, n;
    #1;
    rdy = (trk.size() < DEPTH) && (!req_v || bus.i_dmem_req_ready);
    check_eq("ready", bus.o_ready, rdy);
    check_eq("req_valid", bus.o_dmem_req_valid, req_v);
    check_eq("busy", bus.o_busy, trk.size() != 0 || req_v);
    check_eq("valid", bus.o_valid, ret_v);
    if (req_v) begin
      check_eq("req_addr", bus.o_dmem_addr, req_addr);
      check_eq("req_we", bus.o_dmem_we, req_we);
      check_eq("req_wdata", bus.o_dmem_wdata, req_wdata);
      check_eq("req_wstrb", bus.o_dmem_wstrb, req_wstrb);
    end
    if (ret_v) begin
      check_eq("ret_rd", bus.o_rd, ret_rd);
      check_eq("ret_is_load", bus.o_is_load, ret_load);
      check_eq("ret_data", bus.o_load_data, ret_data);
      check_eq("ret_misaligned", bus.o_misaligned, ret_mis);
      check_eq("ret_fault_addr", bus.o_fault_addr, ret_faddr);
    end
    ret_v = 1'b0;
    if (trk.size() != 0) begin
      h = trk[0];
      if (h.fault || bus.i_dmem_rsp_valid) begin
        ret_v     = 1'b1;
        ret_rd    = h.rd;
        ret_load  = h.load;
        ret_mis   = h.fault;
        ret_faddr = h.fault ? h.addr : 32'd0;
        ret_data  = (h.load && !h.fault) ? load_result(bus.i_dmem_rdata, h) : 32'd0;
        if (!h.fault) issued--;
        void'(trk.pop_front());
      end
    end
    if (req_v && bus.i_dmem_req_ready) begin
      req_v = 1'b0;
      issued++;
    end
    if (bus.i_valid && rdy && (bus.i_is_load || bus.i_is_store)) begin
      n.rd = bus.i_rd; n.load = bus.i_is_load; n.size = bus.i_size; n.sext = bus.i_sign_ext;
      n.addr  = bus.i_base + bus.i_imm;
      n.fault = is_misaligned(n.addr, n.size);
      trk.push_back(n);
      if (!n.fault) begin
        req_v     = 1'b1;
        req_addr  = n.addr;
        req_we    = !n.load;
        req_wdata = (bus.i_wdata & size_mask(n.size)) << (8 * n.addr[1:0]);
        req_wstrb = n.load ? 4'h0 : size_strb(n.size) << n.addr[1:0];
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_random(input int rdy_pct, input int rsp_pct);
    int k;
    k = $urandom_range(0, 4);
    set_op($urandom_range(0, 3) != 0, k < 2, k == 2 || k == 3, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 7), $urandom);
    bus.i_dmem_req_ready = $urandom_range(0, 99) < rdy_pct;
    bus.i_dmem_rsp_valid = rsp_ok() && ($urandom_range(0, 99) < rsp_pct);
    bus.i_dmem_rdata     = $urandom;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_valid", bus.o_valid, 1'b0);
    check_eq("rst_busy", bus.o_busy, 1'b0);
    check_eq("rst_req_valid", bus.o_dmem_req_valid, 1'b0);
    check_eq("rst_load_data", bus.o_load_data, 32'd0);

    // Word store with response two cycles after the request.
    bus.i_dmem_req_ready = 1'b1;
    set_op(1, 0, 1, 2'd2, 0, 5'd1, 32'h100, 32'h4, 32'hDEAD_BEEF);
    tick();
    bus.i_valid = 1'b0;
    #1;
    check_eq("st_addr", bus.o_dmem_addr, 32'h104);
    check_eq("st_we", bus.o_dmem_we, 1'b1);
    check_eq("st_wstrb", bus.o_dmem_wstrb, 4'hF);
    check_eq("st_wdata", bus.o_dmem_wdata, 32'hDEAD_BEEF);
    tick();
    tick();
    bus.i_dmem_rsp_valid = 1'b1; bus.i_dmem_rdata = $urandom;
    tick();
    bus.i_dmem_rsp_valid = 1'b0;
    #1;
    check_eq("st_ret_valid", bus.o_valid, 1'b1);
    check_eq("st_ret_data", bus.o_load_data, 32'd0);
    tick();

    // Byte load at 0x203, signed then unsigned.
    for (int s = 1; s >= 0; s--) begin
      set_op(1, 1, 0, 2'd0, 1'(s), 5'd2, 32'h200, 32'h3, 32'd0);
      tick();
      bus.i_valid = 1'b0;
      tick();
      bus.i_dmem_rsp_valid = 1'b1; bus.i_dmem_rdata = 32'h80FF_FF00;
      tick();
      bus.i_dmem_rsp_valid = 1'b0;
      #1;
      check_eq("lb_data", bus.o_load_data, s != 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
      tick();
    end

    // Half store at 0x2, then misaligned half load at 0x1.
    set_op(1, 0, 1, 2'd1, 0, 5'd3, 32'h0, 32'h2, 32'h1234);
    tick();
    bus.i_valid = 1'b0;
    #1;
    check_eq("sh_wstrb", bus.o_dmem_wstrb, 4'hC);
    check_eq("sh_wdata", bus.o_dmem_wdata, 32'h1234_0000);
    tick();
    bus.i_dmem_rsp_valid = 1'b1;
    tick();
    bus.i_dmem_rsp_valid = 1'b0;
    tick();
    set_op(1, 1, 0, 2'd1, 0, 5'd4, 32'h0, 32'h1, 32'd0);
    tick();
    bus.i_valid = 1'b0;
    #1;
    check_eq("lh_no_req", bus.o_dmem_req_valid, 1'b0);
    tick();
    check_eq("lh_valid", bus.o_valid, 1'b1);
    check_eq("lh_misaligned", bus.o_misaligned, 1'b1);
    check_eq("lh_fault_addr", bus.o_fault_addr, 32'h1);
    tick();

    // Fill the tracker with five loads and no responses.
    for (int i = 1; i <= 5; i++) begin
      set_op(1, 1, 0, 2'd2, 0, 5'(i), 32'h40 * i, 32'd0, 32'd0);
      tick();
    end
    #1;
    check_eq("full_ready", bus.o_ready, 1'b0);
    bus.i_dmem_rsp_valid = 1'b1; bus.i_dmem_rdata = $urandom;
    tick();
    bus.i_dmem_rsp_valid = 1'b0;
    #1;
    check_eq("order_rd1", bus.o_rd, 5'd1);
    check_eq("slot_free", bus.o_ready, 1'b1);
    tick();
    bus.i_valid = 1'b0;
    for (int r = 2; r <= 5; r++) begin
      bus.i_dmem_rsp_valid = 1'b1; bus.i_dmem_rdata = $urandom;
      tick();
      bus.i_dmem_rsp_valid = 1'b0;
      #1;
      check_eq("order_rd", bus.o_rd, 5'(r));
    end
    tick();

    // Reset with three ops in flight; a response during reset must not retire anything.
    for (int i = 6; i <= 8; i++) begin
      set_op(1, 1, 0, 2'd2, 0, 5'(i), 32'h80, 32'd0, 32'd0);
      tick();
    end
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", bus.o_busy, 1'b0);
    check_eq("mid_rst_req", bus.o_dmem_req_valid, 1'b0);
    check_eq("mid_rst_wstrb", bus.o_dmem_wstrb, 4'h0);
    check_eq("mid_rst_addr", bus.o_dmem_addr, 32'd0);
    model_reset();
    bus.i_dmem_rsp_valid = 1'b1; bus.i_dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    check_eq("stray_rsp", bus.o_valid, 1'b0);
    @(negedge clk);
    bus.i_dmem_rsp_valid = 1'b0;
    rst_n = 1'b1;

    // Random traffic under varying back-pressure and response rates.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 400; c++) begin
        case (p)
          0:       drive_random(90, 60);
          1:       drive_random(50, 30);
          2:       drive_random(20, 10);
          default: drive_random(100, 90);
        endcase
        tick();
      end
    end

    idle_inputs();
    for (int c = 0; c < 200 && (trk.size() != 0 || req_v); c++) begin
      bus.i_dmem_req_ready = 1'b1;
      bus.i_dmem_rsp_valid = rsp_ok();
      bus.i_dmem_rdata     = $urandom;
      tick();
    end
    idle_inputs();
    tick();
    check_eq("drained", bus.o_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
